// File: rtl/status_pkg.sv
// Shared definitions for the status register and its save/restore stack.
package status_pkg;

   // Flag bit positions within the status word
   localparam int unsigned STAT_Z = 0;
   localparam int unsigned STAT_C = 1;
   localparam int unsigned STAT_N = 2;
   localparam int unsigned STAT_V = 3;

   // Write source select encoding
   localparam logic SEL_ALU = 1'b1;
   localparam logic SEL_DEC = 1'b0;

   localparam int unsigned DEFAULT_NUM_STATUS_BITS = 4;

   // Resolved stack operation for one cycle
   typedef enum logic [1:0] {
      OP_NONE = 2'd0,
      OP_PUSH = 2'd1,
      OP_POP  = 2'd2,
      OP_SWAP = 2'd3
   } lifo_op_e;

endpackage

// File: rtl/status_lifo.sv
// LIFO of saved status words: storage, level counter, full/empty decode, swap path.
module status_lifo
   import status_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_NUM_STATUS_BITS,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             res_n,
   input  lifo_op_e         op,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] top,
   output logic [LVL_W-1:0] level,
   output logic             empty,
   output logic             full
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0] wr_idx;
   logic [IDX_W-1:0] top_idx;

   assign wr_idx  = IDX_W'(level);
   assign top_idx = IDX_W'(level - LVL_W'(1));
   assign empty   = (level == '0);
   assign full    = (level == LVL_W'(DEPTH));
   assign top     = empty ? '0 : mem[top_idx];

   // Storage and level update; the op is already qualified against full/empty
   always_ff @(posedge clk) begin
      if (!res_n) begin
         level <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (op)
            OP_PUSH: begin
               mem[wr_idx] <= din;
               level       <= level + LVL_W'(1);
            end
            OP_POP:  level <= level - LVL_W'(1);
            OP_SWAP: mem[top_idx] <= din;
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/status_reg_stack.sv
// Status register with masked write, save/restore stack and sticky stack errors.
module status_reg_stack
   import status_pkg::*;
#(
   parameter int unsigned NUM_STATUS_BITS = DEFAULT_NUM_STATUS_BITS,
   parameter int unsigned STACK_DEPTH     = 4,
   parameter int unsigned LVL_W           = $clog2(STACK_DEPTH + 1)
) (
   input  logic                       clk,
   input  logic                       res_n,
   input  logic                       wr_en,
   input  logic                       sel_stat_in_alu_decoder,
   input  logic [NUM_STATUS_BITS-1:0] alu_status,
   input  logic [NUM_STATUS_BITS-1:0] dec_status,
   input  logic [NUM_STATUS_BITS-1:0] wr_mask,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       err_clr,
   output logic [NUM_STATUS_BITS-1:0] status,
   output logic [LVL_W-1:0]           stack_level,
   output logic                       stack_empty,
   output logic                       stack_full,
   output logic                       ovf_err,
   output logic                       unf_err
);

   logic [NUM_STATUS_BITS-1:0] src;
   logic [NUM_STATUS_BITS-1:0] masked_wr;
   logic [NUM_STATUS_BITS-1:0] top;
   logic                       pop_ok;
   logic                       ovf_set;
   logic                       unf_set;
   lifo_op_e                   lifo_op;

   assign src       = (sel_stat_in_alu_decoder == SEL_ALU) ? alu_status : dec_status;
   assign masked_wr = (src & wr_mask) | (status & ~wr_mask);
   assign pop_ok    = pop && !stack_empty;
   // A push while full that coincides with a valid pop is a swap, not an overflow
   assign ovf_set   = push && stack_full && !pop_ok;
   assign unf_set   = pop && stack_empty;

   // Resolve push/pop into a single stack operation
   always_comb begin
      lifo_op = OP_NONE;
      if (push && pop_ok)
         lifo_op = OP_SWAP;
      else if (push && !stack_full)
         lifo_op = OP_PUSH;
      else if (pop_ok)
         lifo_op = OP_POP;
   end

   status_lifo #(
      .WIDTH (NUM_STATUS_BITS),
      .DEPTH (STACK_DEPTH),
      .LVL_W (LVL_W)
   ) u_lifo (
      .clk   (clk),
      .res_n (res_n),
      .op    (lifo_op),
      .din   (status),
      .top   (top),
      .level (stack_level),
      .empty (stack_empty),
      .full  (stack_full)
   );

   // Status register: a valid pop (or swap) restores and drops any write
   always_ff @(posedge clk) begin
      if (!res_n)
         status <= '0;
      else if (pop_ok)
         status <= top;
      else if (wr_en)
         status <= masked_wr;
   end

   // Sticky error flags; a new error in the clearing cycle wins
   always_ff @(posedge clk) begin
      if (!res_n) begin
         ovf_err <= 1'b0;
         unf_err <= 1'b0;
      end else begin
         ovf_err <= (ovf_err && !err_clr) || ovf_set;
         unf_err <= (unf_err && !err_clr) || unf_set;
      end
   end

endmodule

// File: doc/status_reg_stack.md
# status_reg_stack

Parametrised status register with an integrated save/restore stack for the 8-bit core. Like the current status register, it latches flags from either the ALU or the decoder under a write enable. It adds three things on top of that:
- a per-bit write mask, so an operation updates only the flags it owns;
- a LIFO of saved status words, used for interrupt entry/exit and call-with-flags;
- sticky overflow/underflow error flags.

It sits between the ALU/decoder and the control unit, which consumes `status` for conditional jumps.

## Interface
Parameters:
- `NUM_STATUS_BITS`, default 4: width of the status word.
- `STACK_DEPTH`, default 4: number of saved status words (≥1).
- `LVL_W`, default `$clog2(STACK_DEPTH+1)`: width of `stack_level` (derived, not overridden).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `res_n`  in  1  reset; synchronous, active-low.
- `wr_en`  in  1  status write request.
- `sel_stat_in_alu_decoder`  in  1  write source select: 1 = ALU, 0 = decoder.
- `alu_status`  in  NUM_STATUS_BITS  flags from the ALU.
- `dec_status`  in  NUM_STATUS_BITS  flags from the decoder.
- `wr_mask`  in  NUM_STATUS_BITS  per-bit write enable; 1 = bit may update.
- `push`  in  1  save the current status word onto the stack.
- `pop`  in  1  restore status from the top of the stack.
- `err_clr`  in  1  clears both sticky error flags.
- `status`  out  NUM_STATUS_BITS  registered status word.
- `stack_level`  out  LVL_W  number of valid stack entries.
- `stack_empty`  out  1  high when `stack_level == 0`.
- `stack_full`  out  1  high when `stack_level == STACK_DEPTH`.
- `ovf_err`  out  1  sticky; a push was attempted while full.
- `unf_err`  out  1  sticky; a pop was attempted while empty.

## Operation
- **Source:** `src = sel_stat_in_alu_decoder ? alu_status : dec_status`.
- **Write:** if `wr_en`, `status_next[i] = wr_mask[i] ? src[i] : status[i]`. If `wr_en=0`, `status` holds.
- **Push (not full):** stack[level] ← current `status` (the pre-write value); level += 1. A write in the same cycle still applies to `status`.
- **Push while full:** no stack change; `ovf_err` ← 1; any write still applies.
- **Pop (not empty):** `status` ← stack[level-1]; level -= 1. Pop overrides `wr_en` in that cycle, so the write is dropped.
- **Pop while empty:** no stack change; `unf_err` ← 1; any write applies normally.
- **Push and pop together, level > 0:** swap. `status` ← top entry; top entry ← old `status`; level unchanged; `wr_en` is ignored.
- **Push and pop together, level = 0:** pop is ignored and `unf_err` ← 1; push proceeds as a normal push; `wr_en` applies.
- **Error flags:** `err_clr` clears both. If `err_clr` and a new error condition occur in the same cycle, the flag ends up set (set wins).
- **Status flags:** `stack_empty` and `stack_full` are decoded combinationally from the registered level.

## Timing
- All updates are visible one cycle after the qualifying rising edge; there is no combinational path from any input to `status`.
- Reset (`res_n=0` at a rising edge) forces: `status=0`, `stack_level=0`, `ovf_err=0`, `unf_err=0`, all stack entries = 0.
- Reset has priority over every other input, including mid-sequence pushes and pops.
- While `res_n=0`, outputs hold their reset values.
- After reset: `stack_empty=1`, `stack_full=0`.
- Back-to-back pushes or pops, one per cycle, are supported without stall.

## Structure
- Shared package `status_pkg` holds:
  - flag bit-position constants (Z=0, C=1, N=2, V=3);
  - `SEL_ALU=1'b1`, `SEL_DEC=1'b0`;
  - the default `NUM_STATUS_BITS`.
- One sub-module, `status_lifo`. It holds the storage array, the level counter, full/empty decode and the swap path, and is parametrised by width and depth.
- The top level contains the source mux, the write mask, the status register, the priority logic and the error flags.

## Test plan
- **Reset:** hold `res_n=0` for 2 cycles → `status=0000`, `stack_level=0`, `stack_empty=1`, both error flags 0.
- **Source select and mask:** `wr_en=1`, sel=1, `alu_status=0101`, `wr_mask=1111` → `status=0101`. Then sel=0, `dec_status=1010`, `wr_mask=0011` → `status=0110`. Then `wr_en=0`, `alu_status=1111` → `status` stays `0110`.
- **Push/pop restore:** `status=0110`, push while writing ALU `1001` (mask `1111`) → `status=1001`, `level=1`. Next cycle pop → `status=0110`, `level=0`.
- **Overflow (DEPTH=4):** 4 pushes → `stack_full=1`. 5th push → `ovf_err=1`, `level=4`. Then `err_clr` → `ovf_err=0`.
- **Underflow:** pop on empty stack with `wr_en=1`, `dec_status=0011` → `unf_err=1`, `status=0011`, `level=0`.
- **Swap and reset mid-operation:** at `level=1` with top entry=`0001` and `status=1000`, push+pop → `status=0001`, top entry=`1000`, `level=1`. Then `res_n=0` during a push → `level=0`, `status=0000`.
